// File: rtl/core_pkg.sv
// Shared encodings for the RV32I pipeline: datapath width, operand-source selects, ALU codes.
package core_pkg;

  localparam int XLEN   = 32;
  localparam int RIDX_W = 5;

  localparam logic       ASRC_RS1  = 1'b0;
  localparam logic       ASRC_PC   = 1'b1;

  localparam logic [1:0] BSRC_RS2  = 2'b00;
  localparam logic [1:0] BSRC_IMM  = 2'b01;
  localparam logic [1:0] BSRC_FOUR = 2'b10;
  localparam logic [1:0] BSRC_RSVD = 2'b11;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  // Immediate-style constant of width w; keeps the B-operand mux free of literal casts.
  function automatic logic [XLEN-1:0] const_four();
    logic [XLEN-1:0] v;
    v = '0;
    v[2] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Resolves one source operand: x0 -> 0, else EX result, else MEM data, else register file.
// Purely combinational; EX wins over MEM because it is the younger producer.
module fwd_mux #(
  parameter int XLEN   = 32,
  parameter int RIDX_W = 5
) (
  input  logic [RIDX_W-1:0] i_idx,
  input  logic [XLEN-1:0]   i_rf_data,
  input  logic              i_ex_en,
  input  logic [RIDX_W-1:0] i_ex_rd,
  input  logic [XLEN-1:0]   i_ex_data,
  input  logic              i_mem_en,
  input  logic [RIDX_W-1:0] i_mem_rd,
  input  logic [XLEN-1:0]   i_mem_data,
  output logic [XLEN-1:0]   o_data
);

  logic w_is_x0;
  logic w_ex_hit;
  logic w_mem_hit;

  assign w_is_x0   = (i_idx == '0);
  assign w_ex_hit  = i_ex_en  && (i_ex_rd  == i_idx);
  assign w_mem_hit = i_mem_en && (i_mem_rd == i_idx);

  always_comb begin
    o_data = i_rf_data;
    if (w_is_x0) begin
      o_data = '0;
    end else if (w_ex_hit) begin
      o_data = i_ex_data;
    end else if (w_mem_hit) begin
      o_data = i_mem_data;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register with operand select and EX/MEM forwarding; 1 cycle decode -> ALU operands.
// Load-use stalls decode for exactly one bubble; flush kills the entering instruction and overrides stall.
module ex_operand_stage
  import core_pkg::*;
#(
  parameter int XLEN   = core_pkg::XLEN,
  parameter int RIDX_W = core_pkg::RIDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [RIDX_W-1:0] id_rs1,
  input  logic [RIDX_W-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_asrc,
  input  logic [1:0]        id_bsrc,
  input  logic [3:0]        id_aluctr,
  input  logic [RIDX_W-1:0] id_rd,
  input  logic              id_regwr,
  input  logic              id_memrd,
  input  logic              id_memwr,
  input  logic [XLEN-1:0]   ex_result,
  input  logic              mem_valid,
  input  logic              mem_regwr,
  input  logic [RIDX_W-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              flush,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_dataa,
  output logic [XLEN-1:0]   ex_datab,
  output logic [3:0]        ex_aluctr,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [RIDX_W-1:0] ex_rd,
  output logic              ex_regwr,
  output logic              ex_memrd,
  output logic              ex_memwr
);

  logic              r_valid;
  logic [XLEN-1:0]   r_dataa;
  logic [XLEN-1:0]   r_datab;
  logic [3:0]        r_aluctr;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_store;
  logic [RIDX_W-1:0] r_rd;
  logic              r_regwr;
  logic              r_memrd;
  logic              r_memwr;

  logic              w_ex_fwd_en;
  logic              w_mem_fwd_en;
  logic [XLEN-1:0]   w_rs1_fwd;
  logic [XLEN-1:0]   w_rs2_fwd;
  logic [XLEN-1:0]   w_opa;
  logic [XLEN-1:0]   w_opb;
  logic              w_rs1_dep;
  logic              w_rs2_dep;
  logic              w_load_use;

  // A load in EX has no data yet; its ALU result is the address and must not be forwarded.
  assign w_ex_fwd_en  = r_valid && r_regwr && !r_memrd;
  assign w_mem_fwd_en = mem_valid && mem_regwr;

  fwd_mux #(.XLEN(XLEN), .RIDX_W(RIDX_W)) u_fwd_rs1 (
    .i_idx      (id_rs1),
    .i_rf_data  (id_rs1_data),
    .i_ex_en    (w_ex_fwd_en),
    .i_ex_rd    (r_rd),
    .i_ex_data  (ex_result),
    .i_mem_en   (w_mem_fwd_en),
    .i_mem_rd   (mem_rd),
    .i_mem_data (mem_data),
    .o_data     (w_rs1_fwd)
  );

  fwd_mux #(.XLEN(XLEN), .RIDX_W(RIDX_W)) u_fwd_rs2 (
    .i_idx      (id_rs2),
    .i_rf_data  (id_rs2_data),
    .i_ex_en    (w_ex_fwd_en),
    .i_ex_rd    (r_rd),
    .i_ex_data  (ex_result),
    .i_mem_en   (w_mem_fwd_en),
    .i_mem_rd   (mem_rd),
    .i_mem_data (mem_data),
    .o_data     (w_rs2_fwd)
  );

  always_comb begin
    w_opa = w_rs1_fwd;
    if (id_asrc == ASRC_PC) begin
      w_opa = id_pc;
    end
  end

  always_comb begin
    w_opb = '0;
    case (id_bsrc)
      BSRC_RS2:  w_opb = w_rs2_fwd;
      BSRC_IMM:  w_opb = id_imm;
      BSRC_FOUR: w_opb = const_four();
      default:   w_opb = '0;
    endcase
  end

  assign w_rs1_dep  = id_use_rs1 && (id_rs1 == r_rd);
  assign w_rs2_dep  = id_use_rs2 && (id_rs2 == r_rd);
  assign w_load_use = id_valid && r_valid && r_memrd && (r_rd != '0) && (w_rs1_dep || w_rs2_dep);
  assign id_stall   = w_load_use && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_dataa  <= '0;
      r_datab  <= '0;
      r_aluctr <= '0;
      r_pc     <= '0;
      r_store  <= '0;
      r_rd     <= '0;
      r_regwr  <= 1'b0;
      r_memrd  <= 1'b0;
      r_memwr  <= 1'b0;
    end else if (flush || w_load_use) begin
      // Data fields are left stale; a dead entry is identified by its cleared control bits.
      r_valid  <= 1'b0;
      r_regwr  <= 1'b0;
      r_memrd  <= 1'b0;
      r_memwr  <= 1'b0;
    end else begin
      r_valid  <= id_valid;
      r_dataa  <= w_opa;
      r_datab  <= w_opb;
      r_aluctr <= id_aluctr;
      r_pc     <= id_pc;
      r_store  <= w_rs2_fwd;
      r_rd     <= id_rd;
      r_regwr  <= id_valid && id_regwr;
      r_memrd  <= id_valid && id_memrd;
      r_memwr  <= id_valid && id_memwr;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_dataa      = r_dataa;
  assign ex_datab      = r_datab;
  assign ex_aluctr     = r_aluctr;
  assign ex_pc         = r_pc;
  assign ex_store_data = r_store;
  assign ex_rd         = r_rd;
  assign ex_regwr      = r_regwr;
  assign ex_memrd      = r_memrd;
  assign ex_memwr      = r_memwr;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench: stimulus pushes expected EX-stage contents per cycle, a monitor pops and compares.
module tb_ex_operand_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_use_rs1, id_use_rs2;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_asrc;
  logic [1:0]  id_bsrc;
  logic [3:0]  id_aluctr;
  logic [4:0]  id_rd;
  logic        id_regwr, id_memrd, id_memwr;
  logic [31:0] ex_result;
  logic        mem_valid, mem_regwr;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        flush;
  logic        id_stall, ex_valid;
  logic [31:0] ex_dataa, ex_datab, ex_pc, ex_store_data;
  logic [3:0]  ex_aluctr;
  logic [4:0]  ex_rd;
  logic        ex_regwr, ex_memrd, ex_memwr;

  ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_asrc(id_asrc), .id_bsrc(id_bsrc), .id_aluctr(id_aluctr), .id_rd(id_rd),
    .id_regwr(id_regwr), .id_memrd(id_memrd), .id_memwr(id_memwr),
    .ex_result(ex_result), .mem_valid(mem_valid), .mem_regwr(mem_regwr),
    .mem_rd(mem_rd), .mem_data(mem_data), .flush(flush),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_dataa(ex_dataa), .ex_datab(ex_datab),
    .ex_aluctr(ex_aluctr), .ex_pc(ex_pc), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_regwr(ex_regwr), .ex_memrd(ex_memrd), .ex_memwr(ex_memwr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        chk;
    logic [31:0] a, b, st, pc;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic        rw, mr, mw;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic v, input logic c, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] st, input logic [31:0] pc, input logic [3:0] alu,
                      input logic [4:0] rd, input logic rw, input logic mr, input logic mw);
    exp_t e;
    e.valid = v; e.chk = c; e.a = a; e.b = b; e.st = st; e.pc = pc;
    e.alu = alu; e.rd = rd; e.rw = rw; e.mr = mr; e.mw = mw;
    exp_q.push_back(e);
  endtask

  task automatic bubble();
    push(1'b0, 1'b0, 0, 0, 0, 0, 4'h0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clr();
    id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_asrc = 0; id_bsrc = 2'b00;
    id_aluctr = 0; id_rd = 0; id_regwr = 0; id_memrd = 0; id_memwr = 0;
    ex_result = 0; mem_valid = 0; mem_regwr = 0; mem_rd = 0; mem_data = 0; flush = 0;
  endtask

  task automatic nxt();
    @(negedge clk);
    clr();
  endtask

  task automatic check_stall(input logic exp);
    #1;
    chk("id_stall", {31'd0, id_stall}, {31'd0, exp});
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, ex_valid}, 0);
    chk({tag, "_dataa"}, ex_dataa, 0);
    chk({tag, "_datab"}, ex_datab, 0);
    chk({tag, "_aluctr"}, {28'd0, ex_aluctr}, 0);
    chk({tag, "_pc"}, ex_pc, 0);
    chk({tag, "_store"}, ex_store_data, 0);
    chk({tag, "_rd"}, {27'd0, ex_rd}, 0);
    chk({tag, "_ctrl"}, {29'd0, ex_regwr, ex_memrd, ex_memwr}, 0);
    chk({tag, "_stall"}, {31'd0, id_stall}, 0);
  endtask

  // Monitor: one expectation per cycle, sampled just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
        chk("ex_ctrl", {29'd0, ex_regwr, ex_memrd, ex_memwr}, {29'd0, e.rw, e.mr, e.mw});
        if (e.chk) begin
          chk("ex_dataa", ex_dataa, e.a);
          chk("ex_datab", ex_datab, e.b);
          chk("ex_store_data", ex_store_data, e.st);
          chk("ex_pc", ex_pc, e.pc);
          chk("ex_aluctr", {28'd0, ex_aluctr}, {28'd0, e.alu});
          chk("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
        end
      end
    end
  end

  initial begin
    clr();
    rst_n = 0;
    #2;
    check_all_zero("rst");
    nxt();
    rst_n = 1;

    // addi x5,x0,7 (rf data is garbage, x0 must read 0)
    nxt();
    id_valid = 1; id_pc = 32'h10; id_rs1 = 0; id_use_rs1 = 1; id_rs1_data = 32'hDEAD;
    id_imm = 7; id_bsrc = 2'b01; id_aluctr = 4'b0000; id_rd = 5; id_regwr = 1;
    check_stall(0);
    push(1, 1, 32'h0, 32'h7, 32'h0, 32'h10, 4'b0000, 5'd5, 1, 0, 0);

    // add x6,x5,x5 forwarded from EX
    nxt();
    id_valid = 1; id_pc = 32'h14; id_rs1 = 5; id_rs2 = 5; id_use_rs1 = 1; id_use_rs2 = 1;
    id_rs1_data = 32'h55; id_rs2_data = 32'h55; id_rd = 6; id_regwr = 1; ex_result = 7;
    check_stall(0);
    push(1, 1, 32'h7, 32'h7, 32'h7, 32'h14, 4'b0000, 5'd6, 1, 0, 0);

    // lw x3,4(x2)
    nxt();
    id_valid = 1; id_pc = 32'h18; id_rs1 = 2; id_use_rs1 = 1; id_rs1_data = 32'h100;
    id_imm = 4; id_bsrc = 2'b01; id_rd = 3; id_regwr = 1; id_memrd = 1; ex_result = 32'h77;
    check_stall(0);
    push(1, 1, 32'h100, 32'h4, 32'h0, 32'h18, 4'b0000, 5'd3, 1, 1, 0);

    // sub x4,x3,x1: load-use -> one bubble, then MEM forwarding
    nxt();
    id_valid = 1; id_pc = 32'h1C; id_rs1 = 3; id_rs2 = 1; id_use_rs1 = 1; id_use_rs2 = 1;
    id_rs1_data = 32'h9; id_rs2_data = 32'h11; id_aluctr = 4'b1000; id_rd = 4; id_regwr = 1;
    ex_result = 32'h104;
    check_stall(1);
    bubble();
    nxt();
    id_valid = 1; id_pc = 32'h1C; id_rs1 = 3; id_rs2 = 1; id_use_rs1 = 1; id_use_rs2 = 1;
    id_rs1_data = 32'h9; id_rs2_data = 32'h11; id_aluctr = 4'b1000; id_rd = 4; id_regwr = 1;
    mem_valid = 1; mem_regwr = 1; mem_rd = 3; mem_data = 32'h1234;
    check_stall(0);
    push(1, 1, 32'h1234, 32'h11, 32'h11, 32'h1C, 4'b1000, 5'd4, 1, 0, 0);

    // addi x0,x0,1: an EX-stage writer of x0
    nxt();
    id_valid = 1; id_pc = 32'h20; id_use_rs1 = 1; id_imm = 1; id_bsrc = 2'b01;
    id_rd = 0; id_regwr = 1; ex_result = 32'h99;
    check_stall(0);
    push(1, 1, 32'h0, 32'h1, 32'h0, 32'h20, 4'b0000, 5'd0, 1, 0, 0);

    // reads of x0 while EX and MEM both write x0
    nxt();
    id_valid = 1; id_pc = 32'h24; id_use_rs1 = 1; id_use_rs2 = 1;
    id_rs1_data = 32'hAA; id_rs2_data = 32'hAA; id_rd = 9; id_regwr = 1;
    ex_result = 32'h77; mem_valid = 1; mem_regwr = 1; mem_rd = 0; mem_data = 32'hFF;
    push(1, 1, 32'h0, 32'h0, 32'h0, 32'h24, 4'b0000, 5'd9, 1, 0, 0);

    // EX and MEM both target x9: EX wins
    nxt();
    id_valid = 1; id_pc = 32'h28; id_rs1 = 9; id_rs2 = 9; id_use_rs1 = 1; id_use_rs2 = 1;
    id_rs1_data = 32'h33; id_rs2_data = 32'h33; id_rd = 10; id_regwr = 1;
    ex_result = 32'h1; mem_valid = 1; mem_regwr = 1; mem_rd = 9; mem_data = 32'h2;
    push(1, 1, 32'h1, 32'h1, 32'h1, 32'h28, 4'b0000, 5'd10, 1, 0, 0);

    // rs1 from MEM only, rs2 from EX
    nxt();
    id_valid = 1; id_pc = 32'h2C; id_rs1 = 9; id_rs2 = 10; id_use_rs1 = 1; id_use_rs2 = 1;
    id_rs1_data = 32'h33; id_rs2_data = 32'h44; id_rd = 11; id_regwr = 1;
    ex_result = 32'h5; mem_valid = 1; mem_regwr = 1; mem_rd = 9; mem_data = 32'h2;
    push(1, 1, 32'h2, 32'h5, 32'h5, 32'h2C, 4'b0000, 5'd11, 1, 0, 0);

    // lw x3,0(x2) then flushed sw x3,0(x1) that would otherwise stall
    nxt();
    id_valid = 1; id_pc = 32'h30; id_rs1 = 2; id_use_rs1 = 1; id_rs1_data = 32'h300;
    id_bsrc = 2'b01; id_rd = 3; id_regwr = 1; id_memrd = 1;
    push(1, 1, 32'h300, 32'h0, 32'h0, 32'h30, 4'b0000, 5'd3, 1, 1, 0);
    nxt();
    id_valid = 1; id_pc = 32'h34; id_rs1 = 1; id_rs2 = 3; id_use_rs1 = 1; id_use_rs2 = 1;
    id_bsrc = 2'b01; id_memwr = 1; flush = 1;
    check_stall(0);
    bubble();

    // jal: A=pc, B=4
    nxt();
    id_valid = 1; id_pc = 32'h100; id_asrc = 1; id_bsrc = 2'b10; id_rd = 1; id_regwr = 1;
    id_rs1_data = 32'h777;
    push(1, 1, 32'h100, 32'h4, 32'h0, 32'h100, 4'b0000, 5'd1, 1, 0, 0);

    // sw x1,-8(x2): store data forwarded from EX (jal link value)
    nxt();
    id_valid = 1; id_pc = 32'h104; id_rs1 = 2; id_rs2 = 1; id_use_rs1 = 1; id_use_rs2 = 1;
    id_rs1_data = 32'h200; id_rs2_data = 32'h5; id_imm = 32'hFFFF_FFF8; id_bsrc = 2'b01;
    id_memwr = 1; ex_result = 32'h104;
    push(1, 1, 32'h200, 32'hFFFF_FFF8, 32'h104, 32'h104, 4'b0000, 5'd0, 0, 0, 1);

    // reserved B select yields 0
    nxt();
    id_valid = 1; id_pc = 32'h108; id_rs1 = 2; id_rs2 = 1; id_use_rs1 = 1;
    id_rs1_data = 32'h200; id_rs2_data = 32'h5; id_imm = 32'h123; id_bsrc = 2'b11;
    id_aluctr = 4'b1101; id_rd = 7; id_regwr = 1;
    push(1, 1, 32'h200, 32'h0, 32'h5, 32'h108, 4'b1101, 5'd7, 1, 0, 0);

    // asynchronous reset mid-cycle while the stage holds a valid instruction
    nxt();
    #2;
    chk("pre_rst_valid", {31'd0, ex_valid}, 1);
    rst_n = 0;
    #1;
    check_all_zero("async_rst");
    nxt();
    rst_n = 1;
    id_valid = 1; id_pc = 32'h200; id_use_rs1 = 1; id_imm = 32'h55; id_bsrc = 2'b01;
    id_rd = 8; id_regwr = 1;
    push(1, 1, 32'h0, 32'h55, 32'h0, 32'h200, 4'b0000, 5'd8, 1, 0, 0);
    nxt();
    bubble();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
